alu_result_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 23 ++
 rtl/skid_buf2.sv | 104 ++++++++++
 rtl/alu_result_stage.sv | 94 +++++++++
 tb/tb_alu_result_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: default data width,
// ALU op encodings and the skid buffer occupancy states.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    // Number of entries held by the 2-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer. The head register drives the
// output directly; the skid register catches one extra entry so in_ready
// can be a pure function of registered state (no out_ready -> in_ready path).
module skid_buf2
    import alu_pkg::*;
#(
    parameter int unsigned DW    = 20,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    generate
        if (DEPTH != 2) begin : g_bad_depth
            $error("skid_buf2: DEPTH must be 2");
        end
    endgenerate

    skid_state_t   state_q;
    skid_state_t   state_d;
    logic [DW-1:0] head_q;
    logic [DW-1:0] skid_q;
    logic          accept;
    logic          drain;
    logic          load_head_in;
    logic          load_head_skid;
    logic          load_skid;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = head_q;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Next-state and register-load selection from occupancy and handshakes.
    always_comb begin
        state_d        = state_q;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d        = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head and skid payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head_in) begin
                head_q <= in_data;
            end else if (load_head_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result pipeline stage: qualifies ofl/zero by op, buffers results in a
// 2-entry skid buffer and maintains the Z/V/N status flags from ADD results.
// Optional: define ALU_OFL_COUNT_EN to add the saturating ofl_cnt counter.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_out,
    input  logic             in_ofl,
    input  logic             in_zero,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_op,
    output logic             out_ofl,
    output logic             out_zero,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
`ifdef ALU_OFL_COUNT_EN
    ,
    output logic [7:0]       ofl_cnt
`endif
);

    localparam int unsigned DW = WIDTH + 5;

    logic          accept;
    logic          is_add;
    logic          q_ofl;
    logic          q_zero;
    logic [DW-1:0] buf_in;
    logic [DW-1:0] buf_out;

    assign accept = in_valid & in_ready;
    assign is_add = (in_op == OP_ADD);

    // Only ADD produces meaningful ofl/zero; other ops present 0.
    assign q_ofl  = in_ofl & is_add;
    assign q_zero = in_zero & is_add;

    assign buf_in = {in_out, in_op, q_ofl, q_zero};

    skid_buf2 #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (buf_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign out_data = buf_out[DW-1:5];
    assign out_op   = buf_out[4:2];
    assign out_ofl  = buf_out[1];
    assign out_zero = buf_out[0];

    // Status flags track the most recently accepted ADD result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else if (accept && is_add) begin
            flag_z <= in_zero;
            flag_v <= in_ofl;
            flag_n <= in_out[WIDTH-1];
        end
    end

`ifdef ALU_OFL_COUNT_EN
    // Saturating count of accepted ADD results that overflowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofl_cnt <= '0;
        end else if (accept && is_add && in_ofl && (ofl_cnt != 8'hFF)) begin
            ofl_cnt <= ofl_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_out;
    logic        in_ofl;
    logic        in_zero;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_op;
    logic        out_ofl;
    logic        out_zero;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
`ifdef ALU_OFL_COUNT_EN
    logic [7:0]  ofl_cnt;
`endif

    int checks;
    int errors;

    alu_result_stage #(
        .WIDTH (16),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_out    (in_out),
        .in_ofl    (in_ofl),
        .in_zero   (in_zero),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_op    (out_op),
        .out_ofl   (out_ofl),
        .out_zero  (out_zero),
        .flag_z    (flag_z),
        .flag_v    (flag_v),
        .flag_n    (flag_n)
`ifdef ALU_OFL_COUNT_EN
        ,
        .ofl_cnt   (ofl_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] d,
                         input logic z, input logic o);
        in_valid = v;
        in_op    = op;
        in_out   = d;
        in_zero  = z;
        in_ofl   = o;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_op", out_op, 0);
        check("rst_out_ofl", out_ofl, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_flags", {flag_z, flag_v, flag_n}, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();
        check("post_rst_out_valid", out_valid, 0);

        // Single ADD with zero and overflow
        out_ready = 1'b1;
        drive(1'b1, 3'b100, 16'h0000, 1'b1, 1'b1);
        tick();
        check("add_out_valid", out_valid, 1);
        check("add_out_data", out_data, 16'h0000);
        check("add_out_op", out_op, 3'b100);
        check("add_out_zero", out_zero, 1);
        check("add_out_ofl", out_ofl, 1);
        check("add_flags_zvn", {flag_z, flag_v, flag_n}, 3'b110);

        // AND result: qualified zero/ofl are 0, flags unchanged
        drive(1'b1, 3'b101, 16'h8000, 1'b1, 1'b1);
        tick();
        check("and_out_valid", out_valid, 1);
        check("and_out_data", out_data, 16'h8000);
        check("and_out_op", out_op, 3'b101);
        check("and_out_zero", out_zero, 0);
        check("and_out_ofl", out_ofl, 0);
        check("and_flags_zvn", {flag_z, flag_v, flag_n}, 3'b110);

        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        tick();
        check("drain_empty_valid", out_valid, 0);
        check("drain_empty_in_ready", in_ready, 1);

        // Backpressure: three results offered with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 3'b100, 16'h0001, 1'b0, 1'b0);
        tick();
        check("bp1_in_ready", in_ready, 1);
        check("bp1_out_data", out_data, 16'h0001);
        check("bp1_flags_zvn", {flag_z, flag_v, flag_n}, 3'b000);
        drive(1'b1, 3'b100, 16'h0002, 1'b0, 1'b0);
        tick();
        check("bp2_in_ready", in_ready, 0);
        check("bp2_out_data_stable", out_data, 16'h0001);
        drive(1'b1, 3'b100, 16'h0003, 1'b1, 1'b0);
        tick();
        check("bp3_ignored_in_ready", in_ready, 0);
        check("bp3_out_data_stable", out_data, 16'h0001);
        check("bp3_ignored_flag_z", flag_z, 0);
        out_ready = 1'b1;
        tick();
        check("bp_order_2", out_data, 16'h0002);
        check("bp_order_2_valid", out_valid, 1);
        check("bp_after_drain_in_ready", in_ready, 1);
        tick();
        check("bp_order_3", out_data, 16'h0003);
        check("bp_order_3_zero", out_zero, 1);
        check("bp_order_3_flag_z", flag_z, 1);
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        tick();
        check("bp_end_valid", out_valid, 0);

        // Streaming: one result per cycle, latency 1
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 3'b001, 16'h0100 + 16'(i), 1'b1, 1'b1);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, 32'h0100 + 32'(i));
            check("stream_in_ready", in_ready, 1);
            check("stream_ofl_zero", {out_ofl, out_zero}, 0);
        end
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        tick();
        check("stream_end_valid", out_valid, 0);

        // Fill to FULL, then reset asynchronously mid-cycle
        out_ready = 1'b0;
        drive(1'b1, 3'b100, 16'h8000, 1'b0, 1'b0);
        tick();
        check("n_flag_set", {flag_z, flag_v, flag_n}, 3'b001);
        drive(1'b1, 3'b110, 16'h1234, 1'b0, 1'b0);
        tick();
        check("full_in_ready", in_ready, 0);
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_out_op", out_op, 0);
        check("async_rst_flags", {flag_z, flag_v, flag_n}, 0);
        check("async_rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("after_rst_no_stale", out_valid, 0);
        tick();
        check("after_rst_no_stale2", out_valid, 0);

`ifdef ALU_OFL_COUNT_EN
        check("cnt_reset", ofl_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b100, 16'h0001, 1'b0, 1'b1);
            tick();
        end
        check("cnt_three", ofl_cnt, 3);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'b111, 16'h0001, 1'b0, 1'b1);
            tick();
        end
        check("cnt_non_add", ofl_cnt, 3);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 3'b100, 16'h0001, 1'b0, 1'b1);
            tick();
        end
        check("cnt_saturate", ofl_cnt, 8'hFF);
        drive(1'b1, 3'b100, 16'h0001, 1'b0, 1'b1);
        tick();
        check("cnt_hold", ofl_cnt, 8'hFF);
        drive(1'b0, 3'b000, 16'h0000, 1'b0, 1'b0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
